bram_access_arbiter: RTL and testbench

Arbitrates single-port image BRAM access between two requesters: the SPI-side data transfer controller (host load/readback) and the PDI processing engine. It sits between both masters and the BRAM's address, channel, write-enable and data ports. Ownership is round-robin with a bounded burst length, so neither side starves the other. The SPI side can lock ownership for a full-frame readback.

---
 rtl/bram_access_arbiter.sv | 86 ++++++++
 tb/tb_bram_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: round-robin, burst-bounded arbitration of one BRAM port between the SPI and PDI masters
module bram_access_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_req,
    input  logic              spi_lock,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [1:0]        spi_channel,
    input  logic [7:0]        spi_wdata,
    output logic              spi_gnt,
    output logic              spi_rvalid,
    output logic [7:0]        spi_rdata,
    input  logic              pdi_req,
    input  logic              pdi_we,
    input  logic [ADDR_W-1:0] pdi_addr,
    input  logic [1:0]        pdi_channel,
    input  logic [7:0]        pdi_wdata,
    output logic              pdi_gnt,
    output logic              pdi_rvalid,
    output logic [7:0]        pdi_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [1:0]        bram_channel,
    output logic              bram_we,
    output logic [7:0]        bram_data_in,
    input  logic [7:0]        bram_data_out
);
    typedef enum logic [1:0] {IDLE, OWN_SPI, OWN_PDI} state_t;
    state_t state, state_nx, other;
    logic       last_pdi;
    logic [7:0] beat_cnt;
    logic       rd_v, rd_pdi;
    logic       own_req, oth_req, own_we, accepted, burst_done, lock_hold;
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        own_req    = (state == OWN_SPI) ? spi_req : (state == OWN_PDI) ? pdi_req : 1'b0;
        own_we     = (state == OWN_SPI) ? spi_we : (state == OWN_PDI) ? pdi_we : 1'b0;
        oth_req    = (state == OWN_SPI) ? pdi_req : spi_req;
        other      = (state == OWN_SPI) ? OWN_PDI : OWN_SPI;
        accepted   = own_req;
        burst_done = beat_cnt >= 8'(MAX_BURST - 1);
        lock_hold  = (state == OWN_SPI) && spi_lock;
        // the tie in IDLE goes to whichever side did not own the BRAM last
        if (state == IDLE)
            state_nx = (spi_req && (!pdi_req || last_pdi)) ? OWN_SPI : pdi_req ? OWN_PDI : IDLE;
        else if (!own_req)
            state_nx = oth_req ? other : IDLE;
        else
            state_nx = (burst_done && oth_req && !lock_hold) ? other : state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_pdi <= 1'b1;
            beat_cnt <= 8'd0;
            rd_v     <= 1'b0;
            rd_pdi   <= 1'b0;
        end else begin
            if (state_nx != state && state_nx != IDLE) begin
                beat_cnt <= 8'd0;
                last_pdi <= (state_nx == OWN_PDI);
            end else if (accepted && beat_cnt < 8'(MAX_BURST)) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            rd_v   <= accepted && !own_we;
            rd_pdi <= (state == OWN_PDI);
        end
    end
    always_comb begin
        spi_gnt      = (state == OWN_SPI);
        pdi_gnt      = (state == OWN_PDI);
        bram_addr    = spi_gnt ? spi_addr : pdi_gnt ? pdi_addr : '0;
        bram_channel = spi_gnt ? spi_channel : pdi_gnt ? pdi_channel : 2'b00;
        bram_data_in = spi_gnt ? spi_wdata : pdi_gnt ? pdi_wdata : 8'd0;
        bram_we      = accepted && own_we;
        spi_rvalid   = rd_v && !rd_pdi;
        pdi_rvalid   = rd_v && rd_pdi;
        spi_rdata    = bram_data_out;
        pdi_rdata    = bram_data_out;
    end
endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb_bram_access_arbiter: directed + random traffic against a cycle-level ownership model with a scoreboard
module tb_bram_access_arbiter;
    localparam int AW = 17;
    localparam int MB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          spi_req, spi_lock, spi_we, pdi_req, pdi_we;
    logic [AW-1:0] spi_addr, pdi_addr;
    logic [1:0]    spi_channel, pdi_channel;
    logic [7:0]    spi_wdata, pdi_wdata;
    logic          spi_gnt, spi_rvalid, pdi_gnt, pdi_rvalid, bram_we;
    logic [7:0]    spi_rdata, pdi_rdata, bram_data_in, bram_data_out;
    logic [AW-1:0] bram_addr;
    logic [1:0]    bram_channel;

    bram_access_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .spi_req(spi_req), .spi_lock(spi_lock), .spi_we(spi_we), .spi_addr(spi_addr),
        .spi_channel(spi_channel), .spi_wdata(spi_wdata), .spi_gnt(spi_gnt),
        .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
        .pdi_req(pdi_req), .pdi_we(pdi_we), .pdi_addr(pdi_addr),
        .pdi_channel(pdi_channel), .pdi_wdata(pdi_wdata), .pdi_gnt(pdi_gnt),
        .pdi_rvalid(pdi_rvalid), .pdi_rdata(pdi_rdata),
        .bram_addr(bram_addr), .bram_channel(bram_channel), .bram_we(bram_we),
        .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
    );

    function automatic logic [7:0] init_val(int k);
        return 8'(k * 37 + 11) ^ 8'(k >> 8);
    endfunction

    function automatic int key(logic [1:0] c, logic [AW-1:0] a);
        return int'({c, a});
    endfunction

    // environment BRAM: registered read, write-first not modelled (read returns old data)
    logic [7:0] mem [int];
    int         bk;
    always @(posedge clk) begin
        bk = key(bram_channel, bram_addr);
        bram_data_out <= mem.exists(bk) ? mem[bk] : init_val(bk);
        if (bram_we) mem[bk] = bram_data_in;
    end

    typedef struct packed {
        logic          sg, pg, we;
        logic [AW-1:0] addr;
        logic [1:0]    ch;
        logic [7:0]    din;
        logic          srv, prv;
        logic [7:0]    rd;
    } exp_t;
    exp_t q[$];
    exp_t me;
    int vecs = 0, errs = 0;

    // reference model: owner 0 none / 1 SPI / 2 PDI, beats taken in the current tenure
    logic [7:0] ref_mem [int];
    int         m_own = 0, m_last = 2, m_beats = 0, m_pend = 0;
    logic [7:0] m_pdat = 8'd0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("spi_gnt", 32'(spi_gnt), 32'(me.sg));
            chk("pdi_gnt", 32'(pdi_gnt), 32'(me.pg));
            chk("bram_we", 32'(bram_we), 32'(me.we));
            chk("bram_addr", 32'(bram_addr), 32'(me.addr));
            chk("bram_channel", 32'(bram_channel), 32'(me.ch));
            chk("bram_data_in", 32'(bram_data_in), 32'(me.din));
            chk("spi_rvalid", 32'(spi_rvalid), 32'(me.srv));
            chk("pdi_rvalid", 32'(pdi_rvalid), 32'(me.prv));
            if (me.srv) chk("spi_rdata", 32'(spi_rdata), 32'(me.rd));
            if (me.prv) chk("pdi_rdata", 32'(pdi_rdata), 32'(me.rd));
        end
    end

    task automatic push_exp();
        exp_t e;
        e = '0;
        e.sg = (m_own == 1);
        e.pg = (m_own == 2);
        if (m_own == 1) begin
            e.we = spi_req & spi_we; e.addr = spi_addr; e.ch = spi_channel; e.din = spi_wdata;
        end else if (m_own == 2) begin
            e.we = pdi_req & pdi_we; e.addr = pdi_addr; e.ch = pdi_channel; e.din = pdi_wdata;
        end
        e.srv = (m_pend == 1);
        e.prv = (m_pend == 2);
        e.rd  = m_pdat;
        q.push_back(e);
    endtask

    task automatic model_edge();
        logic oreq, ow, otr;
        int other, pick, k;
        oreq = (m_own == 1) ? spi_req : (m_own == 2) ? pdi_req : 1'b0;
        ow   = (m_own == 1) ? spi_we : pdi_we;
        k    = (m_own == 1) ? key(spi_channel, spi_addr) : key(pdi_channel, pdi_addr);
        m_pend = 0;
        if (m_own != 0 && oreq) begin
            if (ow) ref_mem[k] = (m_own == 1) ? spi_wdata : pdi_wdata;
            else begin
                m_pend = m_own;
                m_pdat = ref_mem.exists(k) ? ref_mem[k] : init_val(k);
            end
        end
        if (!rst) begin
            m_own = 0; m_last = 2; m_beats = 0; m_pend = 0;
            return;
        end
        if (m_own == 0) begin
            pick = (spi_req && pdi_req) ? 3 - m_last : spi_req ? 1 : pdi_req ? 2 : 0;
        end else begin
            other = 3 - m_own;
            otr   = (other == 1) ? spi_req : pdi_req;
            if (!oreq) pick = otr ? other : 0;
            else begin
                m_beats++;
                pick = (m_beats >= MB && otr && !(m_own == 1 && spi_lock)) ? other : m_own;
            end
        end
        if (pick != 0 && pick != m_own) begin
            m_beats = 0;
            m_last  = pick;
        end
        m_own = pick;
    endtask

    task automatic step();
        push_exp();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_rand();
        rst      = ($urandom_range(0, 199) != 0);
        spi_lock = ($urandom_range(0, 5) == 0);
        if (!(spi_req && m_own != 1)) begin
            spi_req = ($urandom_range(0, 99) < 70); spi_we = 1'($urandom_range(0, 1));
            spi_addr = AW'($urandom_range(0, 15)); spi_channel = 2'($urandom_range(1, 3));
            spi_wdata = 8'($urandom);
        end
        if (!(pdi_req && m_own != 2)) begin
            pdi_req = ($urandom_range(0, 99) < 70); pdi_we = 1'($urandom_range(0, 1));
            pdi_addr = AW'($urandom_range(0, 15)); pdi_channel = 2'($urandom_range(1, 3));
            pdi_wdata = 8'($urandom);
        end
    endtask

    initial begin
        rst = 1'b0;
        {spi_req, spi_lock, spi_we, pdi_req, pdi_we} = '0;
        spi_addr = '0; pdi_addr = '0; spi_channel = 2'd1; pdi_channel = 2'd2;
        spi_wdata = '0; pdi_wdata = '0;
        @(posedge clk); #1;
        // reset with both sides requesting, then SPI must win the first tie
        spi_req = 1'b1; pdi_req = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        spi_req = 1'b0; pdi_req = 1'b0;
        repeat (2) step();
        // SPI write burst 0..4
        spi_req = 1'b1; spi_we = 1'b1; spi_channel = 2'd1; spi_addr = '0; spi_wdata = 8'hA0;
        step();
        for (int i = 0; i < 5; i++) begin
            spi_addr = AW'(i); spi_wdata = 8'(8'hA0 + i);
            step();
        end
        spi_req = 1'b0; spi_we = 1'b0;
        repeat (2) step();
        // contention: both stream reads
        spi_req = 1'b1; pdi_req = 1'b1;
        for (int n = 0; n < 70; n++) begin
            if (m_own == 1) spi_addr = AW'(n);
            if (m_own == 2) pdi_addr = AW'(100 + n);
            step();
        end
        spi_req = 1'b0; pdi_req = 1'b0;
        repeat (2) step();
        // locked SPI readback with PDI waiting
        spi_lock = 1'b1; spi_req = 1'b1;
        repeat (2) step();
        pdi_req = 1'b1;
        for (int n = 0; n < 300; n++) begin
            spi_addr = AW'(n);
            step();
        end
        spi_req = 1'b0;
        repeat (3) step();
        spi_lock = 1'b0; pdi_req = 1'b0;
        repeat (2) step();
        // read tag crossing a preempting handover
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = AW'(17'h12C00); spi_channel = 2'd1; spi_wdata = 8'h5A;
        repeat (2) step();
        spi_we = 1'b0; pdi_req = 1'b1;
        repeat (20) step();
        spi_req = 1'b0; pdi_req = 1'b0;
        repeat (3) step();
        // reset right behind a PDI read beat
        pdi_req = 1'b1; pdi_we = 1'b0; pdi_addr = AW'(5);
        repeat (2) step();
        rst = 1'b0;
        step();
        rst = 1'b1; pdi_req = 1'b0;
        repeat (2) step();
        for (int n = 0; n < 3000; n++) begin
            drive_rand();
            step();
        end
        rst = 1'b1; spi_req = 1'b0; pdi_req = 1'b0; spi_lock = 1'b0;
        repeat (3) step();
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
